uart_tx_framer: RTL and testbench

Byte-wide UART transmitter for the Bluetooth module link. It consumes the bit-period strobe produced by `timer_10bit` (its `timer_done`) and drives that timer's restart. It serialises one byte per request into an 8-N-1 (or 8-N-2) frame on the `tx` line that feeds the HC-05 RX pin. It sits between the command/data packer (upstream, valid/ready) and the bit timer (sideband).

---
 rtl/uart_tx_framer.sv | 118 +++++++++++
 tb/tb_uart_tx_framer.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_framer.sv
// rtl/uart_tx_framer.sv - byte-wide UART transmit framer driven by an external bit timer
module uart_tx_framer #(
  parameter int DATA_BITS = 8,
  parameter int STOP_BITS = 1
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic [7:0] data_in,
  input  logic       data_valid,
  output logic       data_ready,
  input  logic       baud_tick,
  output logic       timer_restart,
  output logic       timer_active,
  output logic       tx,
  output logic       busy
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  localparam logic [2:0] LAST_DATA = 3'(DATA_BITS - 1);
  localparam logic [2:0] LAST_STOP = 3'(STOP_BITS - 1);
  localparam logic [7:0] DATA_MASK = 8'((1 << DATA_BITS) - 1);

  logic [1:0] state_q, state_d;
  logic [7:0] shift_q, shift_d;
  logic [2:0] cnt_q, cnt_d;
  logic       restart_q, restart_d;
  logic       tx_q, tx_d;
  logic       tick;

  // A tick seen while the timer is being reloaded is stale; dropping it keeps
  // restart pulses at least one cycle apart.
  assign tick = baud_tick && !restart_q;

  // Next-state logic; the bit counter is reused as the stop-bit counter.
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    cnt_d     = cnt_q;
    restart_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (data_valid) begin
          state_d   = S_START;
          shift_d   = data_in & DATA_MASK;
          cnt_d     = 3'd0;
          restart_d = 1'b1;
        end
      end
      S_START: begin
        if (tick) begin
          state_d   = S_DATA;
          restart_d = 1'b1;
        end
      end
      S_DATA: begin
        if (tick) begin
          shift_d   = {1'b0, shift_q[7:1]};
          restart_d = 1'b1;
          if (cnt_q == LAST_DATA) begin
            state_d = S_STOP;
            cnt_d   = 3'd0;
          end else begin
            cnt_d = cnt_q + 3'd1;
          end
        end
      end
      S_STOP: begin
        if (tick) begin
          if (cnt_q != LAST_STOP) begin
            cnt_d     = cnt_q + 3'd1;
            restart_d = 1'b1;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Line level for the upcoming cycle, decoded from next state so tx can be a flop.
  always_comb begin
    tx_d = 1'b1;
    case (state_d)
      S_START: tx_d = 1'b0;
      S_DATA:  tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase
  end

  // State registers; reset aborts any frame in progress and forces the line idle.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q   <= S_IDLE;
      shift_q   <= 8'd0;
      cnt_q     <= 3'd0;
      restart_q <= 1'b0;
      tx_q      <= 1'b1;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      cnt_q     <= cnt_d;
      restart_q <= restart_d;
      tx_q      <= tx_d;
    end
  end

  assign tx            = tx_q;
  assign timer_restart = restart_q;
  assign data_ready    = (state_q == S_IDLE);
  assign busy          = (state_q != S_IDLE);
  assign timer_active  = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_tx_framer.sv
// tb/tb_uart_tx_framer.sv - directed self-checking bench for uart_tx_framer
module tb_uart_tx_framer;

  logic       clock = 1'b0;
  logic       resetn;

  logic [7:0] din_a, din_b;
  logic       vld_a, vld_b, tick_a, tick_b;
  logic       rdy_a, rs_a, act_a, tx_a, busy_a;
  logic       rdy_b, rs_b, act_b, tx_b, busy_b;

  int         cur;
  logic       m_tx, m_rdy, m_busy, m_act, m_rs;

  int         checks = 0;
  int         errors = 0;

  uart_tx_framer dut_a (
    .clock(clock), .resetn(resetn), .data_in(din_a), .data_valid(vld_a),
    .data_ready(rdy_a), .baud_tick(tick_a), .timer_restart(rs_a),
    .timer_active(act_a), .tx(tx_a), .busy(busy_a)
  );

  uart_tx_framer #(.DATA_BITS(7), .STOP_BITS(2)) dut_b (
    .clock(clock), .resetn(resetn), .data_in(din_b), .data_valid(vld_b),
    .data_ready(rdy_b), .baud_tick(tick_b), .timer_restart(rs_b),
    .timer_active(act_b), .tx(tx_b), .busy(busy_b)
  );

  always #5 clock = ~clock;

  // Route the selected instance's outputs to a common set of probes.
  always_comb begin
    m_tx = tx_a; m_rdy = rdy_a; m_busy = busy_a; m_act = act_a; m_rs = rs_a;
    if (cur != 0) begin
      m_tx = tx_b; m_rdy = rdy_b; m_busy = busy_b; m_act = act_b; m_rs = rs_b;
    end
  end

  task automatic check(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [7:0] d, input logic t);
    if (cur == 0) begin
      vld_a = v; din_a = d; tick_a = t;
    end else begin
      vld_b = v; din_b = d; tick_b = t;
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Sends one frame and checks each bit at the start and end of its period.
  task automatic run_frame(input logic [7:0] b, input logic [11:0] exp, input int nbits,
                           input int per, input logic keep_valid, input logic tick_on_accept,
                           input string tag);
    int   rs_cnt;
    logic prev_rs;
    check({tag, " ready_before"}, m_rdy, 1'b1);
    drive(1'b1, b, tick_on_accept);
    step();
    rs_cnt  = 0;
    prev_rs = 1'b0;
    for (int i = 0; i < nbits; i++) begin
      for (int c = 0; c < per; c++) begin
        if (m_rs) rs_cnt++;
        check($sformatf("%s restart_not_consecutive b%0d c%0d", tag, i, c), prev_rs & m_rs, 1'b0);
        prev_rs = m_rs;
        if (c == 0) begin
          check($sformatf("%s bit%0d tx_first", tag, i), m_tx, exp[i]);
          check($sformatf("%s bit%0d restart", tag, i), m_rs, 1'b1);
          check($sformatf("%s bit%0d busy", tag, i), m_busy, 1'b1);
          check($sformatf("%s bit%0d timer_active", tag, i), m_act, 1'b1);
          check($sformatf("%s bit%0d ready", tag, i), m_rdy, 1'b0);
        end
        if (c == per - 1) begin
          check($sformatf("%s bit%0d tx_last", tag, i), m_tx, exp[i]);
        end
        drive(keep_valid, ~b, (c == per - 1));
        step();
      end
    end
    check({tag, " end ready"}, m_rdy, 1'b1);
    check({tag, " end busy"}, m_busy, 1'b0);
    check({tag, " end timer_active"}, m_act, 1'b0);
    check({tag, " end tx"}, m_tx, 1'b1);
    check({tag, " end restart"}, m_rs, 1'b0);
    check_int({tag, " restart_count"}, rs_cnt, nbits);
  endtask

  initial begin
    cur    = 0;
    resetn = 1'b0;
    din_a  = 8'h00; vld_a = 1'b1; tick_a = 1'b0;
    din_b  = 8'h00; vld_b = 1'b1; tick_b = 1'b0;

    // Held in reset with data_valid high: line idle, nothing accepted.
    for (int k = 0; k < 4; k++) begin
      step();
      check("rst tx_a", tx_a, 1'b1);
      check("rst ready_a", rdy_a, 1'b1);
      check("rst busy_a", busy_a, 1'b0);
      check("rst active_a", act_a, 1'b0);
      check("rst restart_a", rs_a, 1'b0);
      check("rst tx_b", tx_b, 1'b1);
      check("rst restart_b", rs_b, 1'b0);
    end
    vld_a = 1'b0; vld_b = 1'b0;
    resetn = 1'b1;
    step();
    step();

    // 0xA5, 8-N-1: 0,1,0,1,0,0,1,0,1,1
    run_frame(8'hA5, 12'b0011_0100_1010, 10, 12, 1'b0, 1'b0, "a5");

    // Back-to-back 0x00 then 0xFF with data_valid held high.
    run_frame(8'h00, 12'b0010_0000_0000, 10, 12, 1'b1, 1'b0, "b2b_00");
    run_frame(8'hFF, 12'b0011_1111_1110, 10, 12, 1'b0, 1'b0, "b2b_ff");
    step();

    // Ticks while idle change nothing.
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, 8'h00, 1'b1);
      step();
      check("idle_tick tx", m_tx, 1'b1);
      check("idle_tick ready", m_rdy, 1'b1);
      check("idle_tick busy", m_busy, 1'b0);
      check("idle_tick restart", m_rs, 1'b0);
    end
    drive(1'b0, 8'h00, 1'b0);
    step();

    // Tick coincident with the accept: start bit still lasts a full period.
    // 0xC3: 0,1,1,0,0,0,0,1,1,1
    run_frame(8'hC3, 12'b0011_1000_0110, 10, 12, 1'b0, 1'b1, "tick_on_accept");
    step();

    // Abort 0x3C after the start bit and four data bits.
    drive(1'b1, 8'h3C, 1'b0);
    step();
    drive(1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 5; i++) begin
      for (int c = 0; c < 12; c++) begin
        drive(1'b0, 8'h00, (c == 11));
        step();
      end
    end
    step();
    step();
    check("abort pre busy", m_busy, 1'b1);
    #2;
    resetn = 1'b0;
    #1;
    check("abort async tx", m_tx, 1'b1);
    check("abort async busy", m_busy, 1'b0);
    check("abort async ready", m_rdy, 1'b1);
    check("abort async active", m_act, 1'b0);
    step();
    step();
    resetn = 1'b1;
    step();
    check("abort idle tx", m_tx, 1'b1);
    check("abort idle busy", m_busy, 1'b0);
    check("abort idle restart", m_rs, 1'b0);
    // 0x55: 0,1,0,1,0,1,0,1,0,1
    run_frame(8'h55, 12'b0010_1010_1010, 10, 12, 1'b0, 1'b0, "after_abort_55");

    // Seven data bits, two stop bits: 0x81 -> 0,1,0,0,0,0,0,0,1,1
    cur = 1;
    #1;
    run_frame(8'h81, 12'b0011_0000_0010, 10, 12, 1'b0, 1'b0, "d7s2_81");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
